clint: RTL and testbench

- Core-local interruptor sitting directly downstream of the bus block, on its CLINT port.
- Holds the RISC-V machine timer (mtime, mtimecmp) and the software-interrupt register (msip).
- Serves byte, halfword and word reads and writes issued by the bus.
- Drives the timer and software interrupt request lines toward the interrupt interface.

---
 rtl/clint.sv | 183 ++++++++++++++++++
 tb/tb_clint.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/clint.sv
// Core-local interruptor (CLINT) for a single hart.
//
// Holds the RISC-V machine timer (mtime, mtimecmp) and the software-interrupt
// bit (msip). It serves byte, halfword and word accesses from the bus and drives
// the timer and software interrupt lines.
//
// Ports:
//   clk, rst                  core clock; asynchronous active-high reset
//   bus_clint_read_addr/size  read byte address and size (1, 2 or 4 bytes)
//   bus_clint_rd              one-cycle read strobe
//   bus_clint_write_addr/size write byte address and size (1, 2 or 4 bytes)
//   bus_clint_data            write data, right-justified
//   bus_clint_wr              one-cycle write strobe
//   clint_bus_data            registered read data, valid the cycle after rd
//   clint_intif_software_int  msip[0]
//   clint_intif_timer_int     mtime >= mtimecmp (unsigned, 64 bit)
//
// Register offsets within the 64 KiB window:
//   0x0000 msip, 0x4000/0x4004 mtimecmp lo/hi, 0xBFF8/0xBFFC mtime lo/hi.
module clint #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned SIZE_WIDTH     = 3,
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter int unsigned BUS_DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] CLINT_BASE = 'h0200_0000,
  parameter int unsigned MTIME_DIV      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     bus_clint_read_addr,
  input  logic [SIZE_WIDTH-1:0]     bus_clint_read_size,
  input  logic                      bus_clint_rd,
  input  logic [ADDR_WIDTH-1:0]     bus_clint_write_addr,
  input  logic [SIZE_WIDTH-1:0]     bus_clint_write_size,
  input  logic [REG_DATA_WIDTH-1:0] bus_clint_data,
  input  logic                      bus_clint_wr,
  output logic [BUS_DATA_WIDTH-1:0] clint_bus_data,
  output logic                      clint_intif_software_int,
  output logic                      clint_intif_timer_int
);

  localparam logic [15:0] OffMsip      = 16'h0000;
  localparam logic [15:0] OffMtimecmpL = 16'h4000;
  localparam logic [15:0] OffMtimecmpH = 16'h4004;
  localparam logic [15:0] OffMtimeL    = 16'hBFF8;
  localparam logic [15:0] OffMtimeH    = 16'hBFFC;

  localparam logic [15:0] PrescMax = 16'(MTIME_DIV - 1);

  // Legal accesses: size 1, 2 or 4 that stay inside one aligned word.
  function automatic logic access_ok(input logic [SIZE_WIDTH-1:0] size,
                                     input logic [1:0] lane);
    logic ok;
    ok = 1'b0;
    if (size == SIZE_WIDTH'(1)) begin
      ok = 1'b1;
    end else if (size == SIZE_WIDTH'(2)) begin
      ok = (lane != 2'd3);
    end else if (size == SIZE_WIDTH'(4)) begin
      ok = (lane == 2'd0);
    end
    return ok;
  endfunction

  function automatic logic [31:0] size_mask(input logic [SIZE_WIDTH-1:0] size);
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    if (size == SIZE_WIDTH'(1)) begin
      m = 32'h0000_00FF;
    end else if (size == SIZE_WIDTH'(2)) begin
      m = 32'h0000_FFFF;
    end
    return m;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  // State
  logic        msip_q, msip_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] rdata_q, rdata_d;

  // Address decode
  logic [ADDR_WIDTH-1:0] rd_rel, wr_rel;
  logic [15:0]           rd_off, wr_off;
  logic [4:0]            rd_shift, wr_shift;
  logic                  rd_ok, wr_ok;
  logic [31:0]           rd_word, rd_val;
  logic [31:0]           wr_word, wr_mask, wr_bits;
  logic                  hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;
  logic                  tick;

  assign rd_rel   = bus_clint_read_addr - CLINT_BASE;
  assign wr_rel   = bus_clint_write_addr - CLINT_BASE;
  assign rd_off   = rd_rel[15:0];
  assign wr_off   = wr_rel[15:0];
  assign rd_shift = {rd_off[1:0], 3'b000};
  assign wr_shift = {wr_off[1:0], 3'b000};
  assign rd_ok    = access_ok(bus_clint_read_size, rd_off[1:0]);
  assign wr_ok    = bus_clint_wr && access_ok(bus_clint_write_size, wr_off[1:0]);

  // Read path: select the word, align the addressed bytes down, trim to size.
  always_comb begin
    rd_word = '0;
    case (rd_off[15:2])
      OffMsip[15:2]:      rd_word = {31'b0, msip_q};
      OffMtimecmpL[15:2]: rd_word = mtimecmp_q[31:0];
      OffMtimecmpH[15:2]: rd_word = mtimecmp_q[63:32];
      OffMtimeL[15:2]:    rd_word = mtime_q[31:0];
      OffMtimeH[15:2]:    rd_word = mtime_q[63:32];
      default:            rd_word = '0;
    endcase
    rd_val  = rd_ok ? ((rd_word >> rd_shift) & size_mask(bus_clint_read_size)) : '0;
    rdata_d = bus_clint_rd ? rd_val : rdata_q;
  end

  // Write path: lane mask and data both shifted up to the addressed bytes.
  assign wr_word     = 32'(bus_clint_data);
  assign wr_mask     = size_mask(bus_clint_write_size) << wr_shift;
  assign wr_bits     = wr_word << wr_shift;
  assign hit_msip    = wr_ok && (wr_off[15:2] == OffMsip[15:2]);
  assign hit_cmp_lo  = wr_ok && (wr_off[15:2] == OffMtimecmpL[15:2]);
  assign hit_cmp_hi  = wr_ok && (wr_off[15:2] == OffMtimecmpH[15:2]);
  assign hit_time_lo = wr_ok && (wr_off[15:2] == OffMtimeL[15:2]);
  assign hit_time_hi = wr_ok && (wr_off[15:2] == OffMtimeH[15:2]);

  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q;
    tick       = (presc_q == PrescMax);
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;

    if (hit_msip && wr_mask[0]) begin
      msip_d = wr_bits[0];
    end
    if (hit_cmp_lo) begin
      mtimecmp_d[31:0] = merge(mtimecmp_q[31:0], wr_bits, wr_mask);
    end
    if (hit_cmp_hi) begin
      mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wr_bits, wr_mask);
    end

    // A write to either mtime word suppresses that cycle's increment entirely.
    if (hit_time_lo || hit_time_hi) begin
      if (hit_time_lo) begin
        mtime_d[31:0] = merge(mtime_q[31:0], wr_bits, wr_mask);
      end
      if (hit_time_hi) begin
        mtime_d[63:32] = merge(mtime_q[63:32], wr_bits, wr_mask);
      end
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip_q     <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
      rdata_q    <= '0;
    end else begin
      msip_q     <= msip_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      rdata_q    <= rdata_d;
    end
  end

  assign clint_bus_data           = BUS_DATA_WIDTH'(rdata_q);
  assign clint_intif_software_int = msip_q;
  assign clint_intif_timer_int    = (mtime_q >= mtimecmp_q);

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint. Two instances share one bus: dut1 counts every
// cycle, dut4 every fourth. Read expectations go into a scoreboard when the
// request is driven and are compared when the registered data appears.
module tb_clint;

  localparam logic [31:0] Base = 32'h0200_0000;

  logic        clk, rst;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [2:0]  rd_size, wr_size;
  logic        rd, wr;
  logic [31:0] rdata1, rdata4;
  logic        sw1, sw4, tm1, tm4;

  int checks = 0;
  int errors = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];
  bit          sel_q[$];

  clint #(.MTIME_DIV(1)) dut1 (
    .clk(clk), .rst(rst),
    .bus_clint_read_addr(rd_addr), .bus_clint_read_size(rd_size), .bus_clint_rd(rd),
    .bus_clint_write_addr(wr_addr), .bus_clint_write_size(wr_size),
    .bus_clint_data(wr_data), .bus_clint_wr(wr),
    .clint_bus_data(rdata1), .clint_intif_software_int(sw1), .clint_intif_timer_int(tm1)
  );

  clint #(.MTIME_DIV(4)) dut4 (
    .clk(clk), .rst(rst),
    .bus_clint_read_addr(rd_addr), .bus_clint_read_size(rd_size), .bus_clint_rd(rd),
    .bus_clint_write_addr(wr_addr), .bus_clint_write_size(wr_size),
    .bus_clint_data(wr_data), .bus_clint_wr(wr),
    .clint_bus_data(rdata4), .clint_intif_software_int(sw4), .clint_intif_timer_int(tm4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge; any read issued last cycle is now visible.
  task automatic step();
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
    while (exp_q.size() > 0) begin
      string t;
      logic [31:0] e;
      bit s;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      chk(t, s ? rdata4 : rdata1, e);
    end
  endtask

  task automatic rd_req(input logic [15:0] off, input logic [2:0] size,
                        input logic [31:0] exp, input string tag, input bit sel = 1'b0);
    rd_addr = Base + {16'h0, off};
    rd_size = size;
    rd      = 1'b1;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    sel_q.push_back(sel);
  endtask

  task automatic wr_req(input logic [15:0] off, input logic [2:0] size,
                        input logic [31:0] data);
    wr_addr = Base + {16'h0, off};
    wr_size = size;
    wr_data = data;
    wr      = 1'b1;
  endtask

  task automatic read(input logic [15:0] off, input logic [2:0] size,
                      input logic [31:0] exp, input string tag);
    rd_req(off, size, exp, tag);
    step();
  endtask

  task automatic write(input logic [15:0] off, input logic [2:0] size,
                       input logic [31:0] data);
    wr_req(off, size, data);
    step();
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; rd_size = 3'd4; wr_size = 3'd4;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_rdata1", rdata1, 32'h0);
    chk("reset_sw1", {31'b0, sw1}, 32'h0);
    chk("reset_tm1", {31'b0, tm1}, 32'h0);

    // Idle count: 10 posedges since release, so mtime is exactly 10.
    repeat (10) step();
    read(16'hBFF8, 3'd4, 32'd10, "idle_mtime_lo");
    read(16'h4000, 3'd4, 32'hFFFF_FFFF, "reset_cmp_lo");
    read(16'h4004, 3'd4, 32'hFFFF_FFFF, "reset_cmp_hi");
    chk("idle_tm1", {31'b0, tm1}, 32'h0);
    chk("idle_sw1", {31'b0, sw1}, 32'h0);

    // msip
    write(16'h0000, 3'd4, 32'h1);
    chk("msip_set", {31'b0, sw1}, 32'h1);
    write(16'h0000, 3'd1, 32'h0);
    chk("msip_byte_clr", {31'b0, sw1}, 32'h0);
    write(16'h0000, 3'd4, 32'hFFFF_FFFF);
    chk("msip_set_all", {31'b0, sw1}, 32'h1);
    read(16'h0000, 3'd4, 32'h1, "msip_read");
    write(16'h0001, 3'd1, 32'h0);
    chk("msip_lane1_nop", {31'b0, sw1}, 32'h1);

    // Timer compare
    write(16'h4004, 3'd4, 32'h0);
    write(16'h4000, 3'd4, 32'h20);
    write(16'hBFF8, 3'd4, 32'h1E);
    chk("tm_at_1e", {31'b0, tm1}, 32'h0);
    step();
    chk("tm_at_1f", {31'b0, tm1}, 32'h0);
    step();
    chk("tm_at_20", {31'b0, tm1}, 32'h1);
    write(16'h4004, 3'd4, 32'h1);
    chk("tm_cmp_hi_raise", {31'b0, tm1}, 32'h0);

    // Low-to-high carry; the high write holds mtime for that cycle
    write(16'hBFF8, 3'd4, 32'hFFFF_FFFF);
    write(16'hBFFC, 3'd4, 32'h0);
    step();
    read(16'hBFF8, 3'd4, 32'h0, "carry_lo");
    read(16'hBFFC, 3'd4, 32'h1, "carry_hi");

    // 64-bit wrap
    write(16'hBFF8, 3'd4, 32'hFFFF_FFFF);
    write(16'hBFFC, 3'd4, 32'hFFFF_FFFF);
    chk("tm_at_max", {31'b0, tm1}, 32'h1);
    step();
    chk("tm_after_wrap", {31'b0, tm1}, 32'h0);
    read(16'hBFF8, 3'd4, 32'h0, "wrap_lo");
    read(16'hBFFC, 3'd4, 32'h0, "wrap_hi");

    // Sub-word and misaligned accesses (mtimecmp lo is 0x20 here)
    write(16'h4002, 3'd2, 32'hBEEF);
    read(16'h4000, 3'd4, 32'hBEEF_0020, "half_wr_cmp_lo");
    read(16'h4003, 3'd1, 32'h0000_00BE, "byte_rd_4003");
    read(16'h4002, 3'd2, 32'h0000_BEEF, "half_rd_4002");
    write(16'h4003, 3'd2, 32'h1234);
    read(16'h4000, 3'd4, 32'hBEEF_0020, "misal_wr_dropped");
    read(16'h4003, 3'd2, 32'h0, "misal_rd_zero");
    read(16'h4000, 3'd3, 32'h0, "size3_rd_zero");
    write(16'h0010, 3'd4, 32'hA5A5_A5A5);
    read(16'h0010, 3'd4, 32'h0, "unmapped_rd");

    // Same-cycle read and write of one register returns the old value
    wr_req(16'h4000, 3'd4, 32'h55);
    rd_req(16'h4000, 3'd4, 32'hBEEF_0020, "rw_same_old");
    step();
    read(16'h4000, 3'd4, 32'h55, "rw_same_new");

    // Prescaled timer on dut4: tick cycles end at posedges 4, 8, ...
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset4_rdata", rdata4, 32'h0);
    chk("reset4_sw", {31'b0, sw4}, 32'h0);
    chk("reset4_tm", {31'b0, tm4}, 32'h0);
    repeat (3) step();
    wr_req(16'hBFF8, 3'd4, 32'h100);
    rd_req(16'hBFF8, 3'd4, 32'h0, "div4_rd_during_wr", 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      rd_req(16'hBFF8, 3'd4, 32'h100, "div4_hold", 1'b1);
      step();
    end
    rd_req(16'hBFF8, 3'd4, 32'h101, "div4_incr", 1'b1);
    step();

    // Reset after a completed read clears the returned data
    read(16'h4004, 3'd4, 32'hFFFF_FFFF, "pre_rst_rd");
    rst = 1'b1;
    #1;
    chk("rst_clears_rdata", rdata1, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_release_rdata", rdata1, 32'h0);

    // Reset overlapping a read in flight: no stale data afterwards
    rd_addr = Base + 32'h4004;
    rd_size = 3'd4;
    rd      = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd  = 1'b0;
    chk("inflight_rd_rst", rdata1, 32'h0);
    step();
    chk("inflight_rd_hold", rdata1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
